// File: rtl/reg_file_arbiter.sv
// Two-requester arbiter in front of a shared 8 x 16-bit register bank.
// Define REG_ARB_ROUND_ROBIN_EN for round-robin tie-break (default: A wins).
module reg_file_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        we_a,
  input  logic        we_b,
  input  logic [2:0]  addr_a,
  input  logic [2:0]  addr_b,
  input  logic [15:0] wdata_a,
  input  logic [15:0] wdata_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        rvalid_a,
  output logic        rvalid_b,
  output logic [15:0] rdata_a,
  output logic [15:0] rdata_b,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [15:0] bank_q [8];

  logic        win_b_q;
  logic        we_q;
  logic [2:0]  addr_q;
  logic [15:0] wdata_q;

  logic        any_req;
  logic        pick_b;
  logic        latch_en;
  logic        bank_we;
  logic        cap_a;
  logic        cap_b;
  logic        finish;

  assign any_req = req_a | req_b;

`ifdef REG_ARB_ROUND_ROBIN_EN
  logic        last_b_q;

  // On a tie, hand the bank to whoever did not win last time.
  assign pick_b = req_b & (~req_a | ~last_b_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_b_q <= 1'b1;
    end else if (finish) begin
      last_b_q <= win_b_q;
    end
  end
`else
  assign pick_b = req_b & ~req_a;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    bank_we  = 1'b0;
    cap_a    = 1'b0;
    cap_b    = 1'b0;
    finish   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          latch_en = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        bank_we = we_q;
        cap_a   = ~we_q & ~win_b_q;
        cap_b   = ~we_q & win_b_q;
        finish  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The in-flight request is frozen here so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_b_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (latch_en) begin
      win_b_q <= pick_b;
      we_q    <= pick_b ? we_b : we_a;
      addr_q  <= pick_b ? addr_b : addr_a;
      wdata_q <= pick_b ? wdata_b : wdata_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        bank_q[i] <= '0;
      end
    end else if (bank_we) begin
      bank_q[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      gnt_a    <= finish & ~win_b_q;
      gnt_b    <= finish & win_b_q;
      rvalid_a <= cap_a;
      rvalid_b <= cap_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (cap_a) begin
        rdata_a <= bank_q[addr_q];
      end
      if (cap_b) begin
        rdata_b <= bank_q[addr_q];
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Scoreboard bench for reg_file_arbiter: latency, arbitration,
// reset abort and in-flight isolation.
module tb_reg_file_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a;
  logic        req_b;
  logic        we_a;
  logic        we_b;
  logic [2:0]  addr_a;
  logic [2:0]  addr_b;
  logic [15:0] wdata_a;
  logic [15:0] wdata_b;
  logic        gnt_a;
  logic        gnt_b;
  logic        rvalid_a;
  logic        rvalid_b;
  logic [15:0] rdata_a;
  logic [15:0] rdata_b;
  logic        busy;

  typedef struct packed {
    logic        b;
    logic        rd;
    logic [15:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] bank_m [8];
  logic [15:0] rd_a_m;
  logic [15:0] rd_b_m;
  int          n_chk = 0;
  int          n_err = 0;

  reg_file_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req_a    (req_a),
    .req_b    (req_b),
    .we_a     (we_a),
    .we_b     (we_b),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .wdata_a  (wdata_a),
    .wdata_b  (wdata_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .rvalid_a (rvalid_a),
    .rvalid_b (rvalid_b),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) bank_m[i] = '0;
    rd_a_m = '0;
    rd_b_m = '0;
    sb.delete();
  endfunction

  function automatic void push(input logic b, input logic we,
                               input logic [2:0] a, input logic [15:0] d);
    exp_t e;
    e.b  = b;
    e.rd = ~we;
    if (we) begin
      bank_m[a] = d;
      e.data    = d;
    end else begin
      e.data = bank_m[a];
    end
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (gnt_a === 1'b1 || gnt_b === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_gnt", {14'd0, gnt_a, gnt_b}, 16'd0);
      end else begin
        e = sb.pop_front();
        check("gnt_a", gnt_a, !e.b);
        check("gnt_b", gnt_b, e.b);
        check("rvalid_a", rvalid_a, !e.b && e.rd);
        check("rvalid_b", rvalid_b, e.b && e.rd);
        if (e.rd) begin
          if (e.b) rd_b_m = e.data;
          else     rd_a_m = e.data;
        end
        check("rdata_a", rdata_a, rd_a_m);
        check("rdata_b", rdata_b, rd_b_m);
      end
    end
  end

  // Called at a negedge with the FSM idle; returns at a negedge, idle again.
  task automatic access(input logic b, input logic we, input logic [2:0] a,
                        input logic [15:0] d, input logic glitch);
    if (b) begin
      req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d;
    end else begin
      req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d;
    end
    push(b, we, a, d);
    @(negedge clk);
    check("busy_n1", busy, 1'b1);
    check("gnt_n1", gnt_a | gnt_b, 1'b0);
    if (glitch) begin
      if (b) begin
        we_b = ~we; addr_b = a + 3'd1; wdata_b = 16'hFFFF;
      end else begin
        we_a = ~we; addr_a = a + 3'd1; wdata_a = 16'hFFFF;
      end
    end
    @(negedge clk);
    check("busy_n2", busy, 1'b1);
    check(b ? "gnt_b_n2" : "gnt_a_n2", b ? gnt_b : gnt_a, 1'b1);
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk);
    check("busy_n3", busy, 1'b0);
    check("gnt_n3", gnt_a | gnt_b, 1'b0);
  endtask

  initial begin
    int ca;
    int cb;
    reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0;
    wdata_a = '0; wdata_b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_gnt", {14'd0, gnt_a, gnt_b}, 16'd0);
    check("rst_rvalid", {14'd0, rvalid_a, rvalid_b}, 16'd0);
    check("rst_rdata_a", rdata_a, 16'h0000);
    check("rst_rdata_b", rdata_b, 16'h0000);
    reset = 1'b0;

    access(1'b0, 1'b0, 3'd5, 16'h0, 1'b0);
    access(1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0);
    access(1'b1, 1'b0, 3'd3, 16'h0, 1'b0);

    // Both requesters held for repeated writes.
    req_a = 1'b1; we_a = 1'b1; addr_a = 3'd2; wdata_a = 16'hA5A5;
    req_b = 1'b1; we_b = 1'b1; addr_b = 3'd4; wdata_b = 16'h5A5A;
`ifdef REG_ARB_ROUND_ROBIN_EN
    push(1'b0, 1'b1, 3'd2, 16'hA5A5);
    push(1'b1, 1'b1, 3'd4, 16'h5A5A);
    push(1'b0, 1'b1, 3'd2, 16'hA5A5);
    push(1'b1, 1'b1, 3'd4, 16'h5A5A);
`else
    push(1'b0, 1'b1, 3'd2, 16'hA5A5);
    push(1'b0, 1'b1, 3'd2, 16'hA5A5);
    push(1'b1, 1'b1, 3'd4, 16'h5A5A);
    push(1'b1, 1'b1, 3'd4, 16'h5A5A);
`endif
    ca = 0;
    cb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt_a === 1'b1) begin
        ca++;
        if (ca == 2) req_a = 1'b0;
      end
      if (gnt_b === 1'b1) begin
        cb++;
        if (cb == 2) req_b = 1'b0;
      end
      if (!req_a && !req_b) break;
    end
    @(negedge clk);
    check("contend_cnt_a", ca[15:0], 16'd2);
    check("contend_cnt_b", cb[15:0], 16'd2);
    check("contend_drain", sb.size(), 16'd0);
    access(1'b0, 1'b0, 3'd2, 16'h0, 1'b0);
    access(1'b1, 1'b0, 3'd4, 16'h0, 1'b0);

    // Reset pulse while the write is in ACCESS.
    req_a = 1'b1; we_a = 1'b1; addr_a = 3'd7; wdata_a = 16'h1234;
    @(negedge clk);
    reset = 1'b1;
    req_a = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("abort_busy", busy, 1'b0);
    check("abort_gnt_a", gnt_a, 1'b0);
    check("abort_rdata_a", rdata_a, 16'h0000);
    @(negedge clk);
    check("abort_gnt_a_n2", gnt_a, 1'b0);
    access(1'b0, 1'b0, 3'd7, 16'h0, 1'b0);

    // Inputs scrambled while the write is in flight.
    access(1'b0, 1'b1, 3'd1, 16'h00AA, 1'b1);
    access(1'b0, 1'b0, 3'd1, 16'h0, 1'b0);
    access(1'b0, 1'b0, 3'd2, 16'h0, 1'b0);
    access(1'b1, 1'b0, 3'd1, 16'h0, 1'b0);

    repeat (3) @(negedge clk);
    check("final_drain", sb.size(), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_arbiter.md
REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous reset, active-high.
REQ-003 SHALL have ports req_a and req_b, input, 1 bit each: access request from requester A or B.
REQ-004 SHALL have ports we_a and we_b, input, 1 bit each: 1 = write, 0 = read.
REQ-005 SHALL have ports addr_a and addr_b, input, 3 bits each: register-bank entry index 0..7.
REQ-006 SHALL have ports wdata_a and wdata_b, input, 16 bits each: write data.
REQ-007 SHALL have ports gnt_a and gnt_b, output, 1 bit each: one-cycle completion pulse, registered.
REQ-008 SHALL have ports rvalid_a and rvalid_b, output, 1 bit each: asserted with gnt when the completed access was a read.
REQ-009 SHALL have ports rdata_a and rdata_b, output, 16 bits each: read result, held until the next read completes for that port.
REQ-010 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-011 SHALL contain an internal bank of 8 x 16-bit load-enabled registers, shared by both requesters.
REQ-012 SHALL implement a three-state FSM: IDLE, ACCESS, DONE.
REQ-013 In IDLE with any req high, the FSM SHALL latch the winner id, we, addr and wdata, then go to ACCESS; with no req it SHALL stay in IDLE.
REQ-014 In ACCESS, the FSM SHALL load the latched entry with latched wdata at the cycle end for a write, or capture that entry into the winner's rdata for a read, then go to DONE.
REQ-015 In DONE, the FSM SHALL drive the winner's gnt for exactly one cycle, plus rvalid for a read, then go to IDLE.
REQ-016 Latency SHALL be fixed: req sampled at edge N; gnt high in cycle N+2; a written value is readable by any access sampled at edge N+3 or later.
REQ-017 A requester SHALL deassert req on the edge ending its gnt cycle; a req high in IDLE SHALL count as a new request.
REQ-018 A request SHALL NOT be dropped: a losing req held high SHALL be served at the next IDLE.
REQ-019 Both requests in the same IDLE cycle SHALL be resolved per REQ-027/REQ-028; only one access SHALL be in flight at any time.
REQ-020 Inputs changing during ACCESS or DONE SHALL NOT affect the in-flight access.
REQ-021 Read and write of the same entry SHALL be serialized by the FSM; a read granted after a write SHALL return the new value.
REQ-022 rdata of the non-winning port SHALL remain unchanged.
REQ-023 Peak throughput SHALL be one access per three cycles.

Reset
REQ-024 While reset is high at a rising edge, the block SHALL force state to IDLE and clear all 8 bank entries to 0x0000.
REQ-025 While reset is high at a rising edge, the block SHALL set gnt_a/b, rvalid_a/b and busy to 0, rdata_a/b to 0x0000, and last winner to B.
REQ-026 Reset asserted during ACCESS or DONE SHALL abort the access: no bank write, no gnt, no rvalid.

Configuration
REQ-027 With macro REG_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port that did not win last, and last winner SHALL update on every grant.
REQ-028 Without REG_ARB_ROUND_ROBIN_EN, A SHALL always win simultaneous requests (fixed priority), and the last-winner register SHALL be absent.

Verification
REQ-029 The bench SHALL cover: reset, then A reads addr 5 -> gnt_a and rvalid_a high in cycle N+2, rdata_a = 0x0000, busy high in cycles N+1..N+2.
REQ-030 The bench SHALL cover: A writes 0xBEEF to addr 3, then B reads addr 3 -> gnt_a with rvalid_a low; B's grant three cycles later with rdata_b = 0xBEEF and rdata_a unchanged.
REQ-031 The bench SHALL cover: A and B held high together for repeated writes -> with REG_ARB_ROUND_ROBIN_EN, grants A,B,A,B; without it, A is granted until req_a drops, then B.
REQ-032 The bench SHALL cover: A writes 0x1234 to addr 7 and reset pulses during ACCESS -> no gnt_a; a later read of addr 7 returns 0x0000.
REQ-033 The bench SHALL cover: wdata_a changed to 0xFFFF during ACCESS of a 0x00AA write to addr 1 -> a later read of addr 1 returns 0x00AA.
